// File: rtl/dm_port_arbiter_if.sv
// Bundle shared by the two data-memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dm_port_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [1:0]  size0;
  logic [1:0]  size1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [31:0] pc4_0;

  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata;
  logic        busy;

  logic        dm_we;
  logic [3:0]  dm_be;
  logic [13:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;
  logic [31:0] dm_pc4;

  modport slave (
    input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, pc4_0, dm_rd,
    output ack0, ack1, err0, err1, rdata, busy, dm_we, dm_be, dm_addr, dm_wd, dm_pc4
  );

  modport master (
    output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, pc4_0, dm_rd,
    input  ack0, ack1, err0, err1, rdata, busy, dm_we, dm_be, dm_addr, dm_wd, dm_pc4
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory: one access in flight,
// IDLE -> ACCESS -> DONE, with lane steering on writes and lane extraction on reads.
module dm_port_arbiter #(
  parameter logic [31:0] MEM_TOP   = 32'h0000_4000,
  parameter bit          FIXED_PRI = 1'b0
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e      state_q;
  logic        rr_last_q;
  logic        port_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        err0_q;
  logic        err1_q;
  logic        busy_q;
  logic [31:0] rdata_q;
  logic        dm_we_q;
  logic [3:0]  dm_be_q;
  logic [13:0] dm_addr_q;
  logic [31:0] dm_wd_q;
  logic [31:0] dm_pc4_q;

  logic        grant;
  logic        win;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] sel_pc4;
  logic        sel_err;
  logic [3:0]  sel_be;
  logic [31:0] sel_wd;
  logic [31:0] rdata_d;

  // Winner selection and the DM-side view of its request, evaluated while IDLE.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    grant     = bus.req0 | bus.req1;
    win       = bus.req1;
    sel_we    = bus.we0;
    sel_size  = bus.size0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    sel_pc4   = bus.pc4_0;
    sel_be    = 4'b0000;
    sel_wd    = 32'h0;

    if (bus.req0 && bus.req1) begin
      win = FIXED_PRI ? 1'b0 : ~rr_last_q;
    end

    if (win) begin
      sel_we    = bus.we1;
      sel_size  = bus.size1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
      sel_pc4   = 32'h0;
    end

    sel_err = (sel_size == 2'd3)
            | ((sel_size == 2'd1) & sel_addr[0])
            | ((sel_size == 2'd2) & (sel_addr[1:0] != 2'b00))
            | (sel_addr >= MEM_TOP);

    case (sel_size)
      2'd0: begin
        sel_be = 4'b0001 << sel_addr[1:0];
        sel_wd = {4{sel_wdata[7:0]}};
      end
      2'd1: begin
        sel_be = sel_addr[1] ? 4'b1100 : 4'b0011;
        sel_wd = {2{sel_wdata[15:0]}};
      end
      default: begin
        sel_be = 4'b1111;
        sel_wd = sel_wdata;
      end
    endcase

    if (sel_err) begin
      sel_be = 4'b0000;
    end
  end

  // Read lane extraction from the latched size and low address bits.
  always_comb begin
    rdata_d = 32'h0;
    if (!err_q) begin
      case (size_q)
        2'd0:    rdata_d = {24'h0, bus.dm_rd[{addr_lo_q, 3'b000} +: 8]};
        2'd1:    rdata_d = addr_lo_q[1] ? {16'h0, bus.dm_rd[31:16]} : {16'h0, bus.dm_rd[15:0]};
        2'd2:    rdata_d = bus.dm_rd;
        default: rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      port_q    <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'd0;
      addr_lo_q <= 2'd0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= 32'h0;
      dm_we_q   <= 1'b0;
      dm_be_q   <= 4'b0000;
      dm_addr_q <= 14'h0;
      dm_wd_q   <= 32'h0;
      dm_pc4_q  <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            rr_last_q <= win;
            port_q    <= win;
            err_q     <= sel_err;
            size_q    <= sel_size;
            addr_lo_q <= sel_addr[1:0];
            busy_q    <= 1'b1;
            dm_we_q   <= sel_we & ~sel_err;
            dm_be_q   <= sel_be;
            dm_addr_q <= sel_addr[13:0];
            dm_wd_q   <= sel_wd;
            dm_pc4_q  <= sel_pc4;
            state_q   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rdata_q   <= rdata_d;
          ack0_q    <= ~port_q;
          ack1_q    <= port_q;
          err0_q    <= ~port_q & err_q;
          err1_q    <= port_q & err_q;
          dm_we_q   <= 1'b0;
          dm_be_q   <= 4'b0000;
          dm_addr_q <= 14'h0;
          dm_wd_q   <= 32'h0;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.err0    = err0_q;
  assign bus.err1    = err1_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.dm_we   = dm_we_q;
  assign bus.dm_be   = dm_be_q;
  assign bus.dm_addr = dm_addr_q;
  assign bus.dm_wd   = dm_wd_q;
  assign bus.dm_pc4  = dm_pc4_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed vector table, multi-cycle corner
// sequences, and random single-port traffic against a byte-level memory model.
module tb_dm_port_arbiter;

  localparam logic [31:0] MEM_TOP = 32'h0000_4000;

  logic clk;
  logic rst;
  logic mem_clr;

  dm_port_arbiter_if b0 ();
  dm_port_arbiter_if b1 ();

  dm_port_arbiter #(.MEM_TOP(MEM_TOP), .FIXED_PRI(1'b0)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  dm_port_arbiter #(.MEM_TOP(MEM_TOP), .FIXED_PRI(1'b1)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory attached to the round-robin instance: sync byte-enabled write, comb read.
  logic [31:0] dm_mem [0:4095];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) dm_mem[i] <= 32'h0;
    end else if (b0.dm_we) begin
      for (int k = 0; k < 4; k++)
        if (b0.dm_be[k]) dm_mem[b0.dm_addr[13:2]][8*k +: 8] <= b0.dm_wd[8*k +: 8];
    end
  end
  assign b0.dm_rd = dm_mem[b0.dm_addr[13:2]];
  assign b1.dm_rd = 32'h0;

  // Reference model: flat byte array plus the access rules in plain arithmetic.
  logic [7:0] ref_bytes [0:16383];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit m_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || ((addr % m_bytes(size)) != 0) || (addr >= MEM_TOP);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int mask;
    if (m_err(size, addr)) return 4'b0000;
    mask = ((1 << m_bytes(size)) - 1) << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    int n;
    n = m_bytes(size);
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] r;
    r = 32'h0;
    if (!m_err(size, addr))
      for (int k = 0; k < m_bytes(size); k++) r[8*k +: 8] = ref_bytes[addr[13:0] + 14'(k)];
    return r;
  endfunction

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc4;
    bit          exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input bit port, input bit we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] pc4, input bit err, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    v.port = port; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.pc4 = pc4;
    v.exp_err = err; v.exp_be = be; v.exp_wd = wd; v.exp_rd = rd;
    return v;
  endfunction

  task automatic drive_idle();
    b0.req0 = 0; b0.req1 = 0; b0.we0 = 0; b0.we1 = 0; b0.size0 = 0; b0.size1 = 0;
    b0.addr0 = 0; b0.addr1 = 0; b0.wdata0 = 0; b0.wdata1 = 0; b0.pc4_0 = 0;
    b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0; b1.size0 = 0; b1.size1 = 0;
    b1.addr0 = 0; b1.addr1 = 0; b1.wdata0 = 0; b1.wdata1 = 0; b1.pc4_0 = 0;
  endtask

  // One complete access on the round-robin instance; scramble rewrites the request
  // fields during ACCESS to show the grant-time values are what reach the memory.
  task automatic do_access(input vec_t v, input bit scramble, input string tag);
    int n;
    bit in_access;
    @(negedge clk);
    check({tag, " idle busy"}, b0.busy, 0);
    b0.pc4_0 = v.pc4;
    if (v.port) begin
      b0.we1 = v.we; b0.size1 = v.size; b0.addr1 = v.addr; b0.wdata1 = v.wdata; b0.req1 = 1;
    end else begin
      b0.we0 = v.we; b0.size0 = v.size; b0.addr0 = v.addr; b0.wdata0 = v.wdata; b0.req0 = 1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      in_access = b0.busy && !b0.ack0 && !b0.ack1;
    end while (!in_access && n < 6);
    check({tag, " grant latency"}, n, 1);
    if (scramble) begin
      b0.addr0 = v.addr + 4; b0.wdata0 = ~v.wdata; b0.pc4_0 = v.pc4 + 4;
      b0.addr1 = v.addr + 4; b0.wdata1 = ~v.wdata;
    end
    check({tag, " dm_we"}, b0.dm_we, v.we && !v.exp_err);
    check({tag, " dm_be"}, b0.dm_be, v.exp_be);
    check({tag, " dm_addr"}, b0.dm_addr, v.addr[13:0]);
    check({tag, " dm_pc4"}, b0.dm_pc4, v.port ? 32'h0 : v.pc4);
    if (v.we && !v.exp_err) check({tag, " dm_wd"}, b0.dm_wd, v.exp_wd);
    @(negedge clk);
    check({tag, " ack own"}, v.port ? b0.ack1 : b0.ack0, 1);
    check({tag, " ack other"}, v.port ? b0.ack0 : b0.ack1, 0);
    check({tag, " err"}, v.port ? b0.err1 : b0.err0, v.exp_err);
    check({tag, " busy in done"}, b0.busy, 1);
    if (!v.we) check({tag, " rdata"}, b0.rdata, v.exp_rd);
    b0.req0 = 0; b0.req1 = 0;
    if (v.we && !m_err(v.size, v.addr))
      for (int k = 0; k < m_bytes(v.size); k++) ref_bytes[v.addr[13:0] + 14'(k)] = v.wdata[8*k +: 8];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   ack_cyc0[$];
    int   ack_port0[$];
    int   ack_port1[$];
    int   sz;
    bit   saw_ack;

    for (int i = 0; i < 16384; i++) ref_bytes[i] = 8'h0;
    drive_idle();
    rst = 1; mem_clr = 1;
    repeat (2) @(negedge clk);
    check("reset busy", b0.busy, 0);
    check("reset ack0", b0.ack0, 0);
    check("reset ack1", b0.ack1, 0);
    check("reset err0", b0.err0, 0);
    check("reset dm_we", b0.dm_we, 0);
    check("reset dm_be", b0.dm_be, 0);
    check("reset dm_addr", b0.dm_addr, 0);
    check("reset dm_wd", b0.dm_wd, 0);
    check("reset rdata", b0.rdata, 0);
    check("reset dm_pc4", b0.dm_pc4, 0);
    rst = 0; mem_clr = 0;

    //            port we size addr           wdata          pc4            err be       wd             rd
    tbl.push_back(mk(0, 1, 2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0104, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h0000_0010, 32'h0,         32'h0000_0108, 0, 4'b1111, 32'h0,         32'hDEAD_BEEF));
    tbl.push_back(mk(0, 1, 0, 32'h0000_0013, 32'h0000_00AB, 32'h0000_010C, 0, 4'b1000, 32'hABAB_ABAB, 32'h0));
    tbl.push_back(mk(0, 1, 2, 32'h0000_0020, 32'h1122_3344, 32'h0000_0110, 0, 4'b1111, 32'h1122_3344, 32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h0000_0022, 32'h0,         32'h0000_0114, 0, 4'b1100, 32'h0,         32'h0000_1122));
    tbl.push_back(mk(0, 0, 0, 32'h0000_0021, 32'h0,         32'h0000_0118, 0, 4'b0010, 32'h0,         32'h0000_0033));
    tbl.push_back(mk(0, 1, 2, 32'h0000_0006, 32'hCAFE_F00D, 32'h0000_011C, 1, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h0000_0004, 32'h0,         32'h0000_0120, 0, 4'b1111, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h0000_4000, 32'h0,         32'h0000_0124, 1, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 3, 32'h0000_0040, 32'h0,         32'h0000_0128, 1, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 2, 32'h0000_0010, 32'h0,         32'h0000_012C, 0, 4'b1111, 32'h0,         32'hABAD_BEEF));
    tbl.push_back(mk(1, 0, 1, 32'h0000_0020, 32'h0,         32'h0000_0130, 0, 4'b0011, 32'h0,         32'h0000_3344));
    tbl.push_back(mk(1, 1, 1, 32'h0000_0032, 32'h0000_BEEF, 32'h0000_0134, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0));
    tbl.push_back(mk(1, 0, 2, 32'h0000_0030, 32'h0,         32'h0000_0138, 0, 4'b1111, 32'h0,         32'hBEEF_0000));
    tbl.push_back(mk(0, 0, 1, 32'h0000_0021, 32'h0,         32'h0000_013C, 1, 4'b0000, 32'h0,         32'h0));
    foreach (tbl[i]) do_access(tbl[i], 0, $sformatf("vec%0d", i));

    // Request fields change during ACCESS; the grant-time values must be used.
    do_access(mk(0, 1, 2, 32'h40, 32'h1234_5678, 32'h0000_1004, 0, 4'b1111, 32'h1234_5678, 32'h0), 1, "latch st");
    do_access(mk(0, 0, 2, 32'h40, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h1234_5678), 0, "latch ld40");
    do_access(mk(0, 0, 2, 32'h44, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0), 0, "latch ld44");

    // Asynchronous reset in the middle of a store's ACCESS cycle.
    @(negedge clk);
    b0.we0 = 1; b0.size0 = 2; b0.addr0 = 32'h38; b0.wdata0 = 32'h55AA_55AA; b0.req0 = 1;
    @(negedge clk);
    check("rstmid dm_we before", b0.dm_we, 1);
    #1 rst = 1;
    #1;
    check("rstmid dm_we after", b0.dm_we, 0);
    check("rstmid busy", b0.busy, 0);
    b0.req0 = 0;
    saw_ack = 0;
    repeat (2) begin
      @(negedge clk);
      saw_ack |= b0.ack0 | b0.ack1;
    end
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      saw_ack |= b0.ack0 | b0.ack1;
    end
    check("rstmid no ack", saw_ack, 0);
    check("rstmid idle", b0.busy, 0);
    v = mk(0, 0, 2, 32'h38, 32'h0, 32'h0, 0, 4'b1111, 32'h0, m_rd(2'd2, 32'h38));
    do_access(v, 0, "rstmid ld");

    // Both ports held high from reset on both instances.
    @(negedge clk);
    rst = 1;
    b0.we0 = 0; b0.size0 = 2; b0.addr0 = 32'h10; b0.req0 = 1;
    b0.we1 = 0; b0.size1 = 2; b0.addr1 = 32'h20; b0.req1 = 1;
    b1.we0 = 0; b1.size0 = 2; b1.addr0 = 32'h10; b1.req0 = 1;
    b1.we1 = 0; b1.size1 = 2; b1.addr1 = 32'h20; b1.req1 = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b0.ack0 || b0.ack1) begin
        ack_cyc0.push_back(c);
        ack_port0.push_back(int'(b0.ack1));
      end
      if (b1.ack0 || b1.ack1) ack_port1.push_back(int'(b1.ack1));
    end
    b0.req0 = 0; b0.req1 = 0; b1.req0 = 0; b1.req1 = 0;
    @(negedge clk);
    check("rr ack count", ack_cyc0.size(), 4);
    check("fixed ack count", ack_port1.size(), 4);
    foreach (ack_port0[i]) check($sformatf("rr grant %0d port", i), ack_port0[i], i % 2);
    for (int i = 1; i < ack_cyc0.size(); i++)
      check($sformatf("rr ack gap %0d", i), ack_cyc0[i] - ack_cyc0[i-1], 3);
    foreach (ack_port1[i]) check($sformatf("fixed grant %0d port", i), ack_port1[i], 0);

    // Random single-port traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      v.port  = 1'($urandom_range(0, 1));
      v.we    = 1'($urandom_range(0, 1));
      sz      = $urandom_range(0, 9);
      v.size  = (sz < 3) ? 2'd0 : (sz < 6) ? 2'd1 : (sz < 9) ? 2'd2 : 2'd3;
      v.addr  = ($urandom_range(0, 15) == 0) ? MEM_TOP + $urandom_range(0, 255) : $urandom_range(0, 127);
      v.wdata = $urandom;
      v.pc4   = $urandom;
      v.exp_err = m_err(v.size, v.addr);
      v.exp_be  = m_be(v.size, v.addr);
      v.exp_wd  = m_wd(v.size, v.wdata);
      v.exp_rd  = m_rd(v.size, v.addr);
      do_access(v, 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
Sequencer and arbiter that shares the single-port data memory (4096 x 32-bit words, byte-enabled, synchronous write, combinational read) between two requesters: port 0 (CPU M-stage) and port 1 (device/DMA master).
- Each access is arbitrated, latched and converted into DM byte-enables, lane-replicated write data and a word index.
- The block then returns lane-extracted read data with a one-cycle ack.
- Misaligned and out-of-range accesses are blocked and flagged.

Parameters:
MEM_TOP, 32'h0000_4000, first byte address beyond DM; addr >= MEM_TOP is an error.
FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
req0 / req1  in  1  access request, held until ackN
we0 / we1  in  1  1 = store, 0 = load
size0 / size1  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as error
addr0 / addr1  in  32  byte address
wdata0 / wdata1  in  32  store data, right-aligned
pc4_0  in  32  CPU PC+4 of the access; port 1 supplies 0
ack0 / ack1  out  1  one-cycle completion pulse
err0 / err1  out  1  valid with ack: misaligned or out-of-range
rdata  out  32  load data, lane shifted to bit 0, zero-extended; valid with ack
busy  out  1  high in ACCESS and DONE
dm_we  out  1  DM write enable
dm_be  out  4  DM byte enables
dm_addr  out  14  DM byte address; DM indexes it with [13:2]
dm_wd  out  32  DM write data
dm_rd  in  32  DM read data (combinational)
dm_pc4  out  32  latched pc4 for DM trace display

Behaviour:
- Reset (async): state = IDLE; rr_last = 1 (port 0 wins the first tie). All outputs 0. A reset during ACCESS drops dm_we immediately, so no DM write occurs and no ack is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose a winner, latch its we, size, addr, wdata, pc4 (0 for port 1) and its port id, then go to ACCESS.
- Arbitration:
  - If only one port requests, that port wins.
  - If both request and FIXED_PRI = 1, port 0 wins.
  - If both request and FIXED_PRI = 0, the port != rr_last wins.
  - rr_last updates to the winner on every grant.
- Error check, computed from latched fields: err = (size == 3) | (size == 1 & addr[0]) | (size == 2 & addr[1:0] != 0) | (addr >= MEM_TOP).
- ACCESS (exactly 1 cycle, then DONE):
  - dm_addr = addr[13:0]; dm_pc4 = latched pc4.
  - dm_we = we & ~err.
  - dm_be:
    - word: 1111
    - half: 0011 when addr[1] = 0, 1100 when addr[1] = 1
    - byte: 0001 << addr[1:0]
    - forced to 0000 on err
  - dm_wd: word = wdata; half = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
  - At the closing edge, capture rdata from dm_rd:
    - word: full dm_rd
    - half: dm_rd[16*addr[1] +: 16], zero-extended
    - byte: dm_rd[8*addr[1:0] +: 8], zero-extended
    - err: 0
  - Stores also capture rdata; requesters ignore it.
- DONE (1 cycle, then IDLE): ackN = 1 for the latched port only; errN = latched err; rdata held.
- Outside ACCESS: dm_we = 0, dm_be = 0, dm_addr and dm_wd = 0.
- Latency: a req first sampled at edge N gives ACCESS in cycle N+1, ack in cycle N+2, and the next grant no earlier than edge N+3. One access is in flight at a time.
- Requester rule: drop req in the ack cycle or in the cycle after. A req still high when IDLE samples it starts a new access.
- A losing requester keeps req high and is served on the next IDLE.
- A req withdrawn before grant is simply not served; no error.
- Changes to addr/wdata/size/we after the grant have no effect, because the fields are latched.

Test Plan:
1. Port 0 word store: addr 0x10, wdata 0xDEADBEEF. Required: ACCESS cycle with dm_we = 1, dm_be = 1111, dm_addr = 0x010; ack0 two cycles after req; then a port-0 word load of 0x10 returns rdata = 0xDEADBEEF, err0 = 0.
2. Byte/half lanes: sb 0xAB at 0x13 gives dm_be = 1000 and dm_wd = 0xABABABAB. With word 0x11223344 at 0x20, lh at 0x22 returns 0x00001122 and lb at 0x21 returns 0x00000033.
3. Errors:
   - Word store at 0x06: dm_we = 0, dm_be = 0000, ack0 with err0 = 1, memory unchanged.
   - Load at MEM_TOP: err = 1, rdata = 0.
   - size = 3: err = 1.
4. Arbitration, FIXED_PRI = 0, req0 and req1 held high from reset: grants alternate 0, 1, 0, 1 with one ack per 3 cycles. With FIXED_PRI = 1 under the same stimulus, port 0 is always granted.
5. Assert reset asynchronously mid-ACCESS of a store: dm_we falls within the same cycle, the target word is unchanged, no ack appears, and state returns to IDLE.
6. Latch check: change addr0 and wdata0 during ACCESS. The DM write uses the values sampled at grant, and dm_pc4 equals the pc4_0 sampled at grant.
